// File: rtl/cpu_param.sv
// Single-cycle parameterised accumulator-free register CPU with a two-state
// memory controller (EXEC / MEM_WAIT) that stalls on BUSYWAIT.
module cpu_param #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   output logic [31:0]       PC,
   input  logic [31:0]       INSTRUCTION,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [7:0]        MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              BUSYWAIT,
   output logic              ILLEGAL
);

   localparam int NREG = 1 << REG_AW;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_BNE   = 8'h08;
   localparam logic [7:0] OP_LWD   = 8'h09;
   localparam logic [7:0] OP_LWI   = 8'h0A;
   localparam logic [7:0] OP_SWD   = 8'h0B;
   localparam logic [7:0] OP_SWI   = 8'h0C;
   localparam logic [7:0] OP_SLL   = 8'h0D;
   localparam logic [7:0] OP_SRL   = 8'h0E;

   typedef enum logic {EXEC, MEM_WAIT} state_t;

   state_t              state, state_nx;
   logic [DATA_W-1:0]   regs [NREG];

   logic [7:0]          opcode, off, imm;
   logic [4:0]          shamt;
   logic [REG_AW-1:0]   rd_idx, rs1_idx, rs2_idx;
   logic [DATA_W-1:0]   rs1_val, rs2_val, imm_ext, alu_res;
   logic [31:0]         pc_plus4, br_target, pc_nx;
   logic                shift_big, wr_en, is_load, is_store, is_mem;
   logic                take_branch, illegal_op;
   logic [7:0]          mem_addr_c;
   logic                unused_bits;

   logic                gap_q, gap_nx;
   logic                rd_q, wr_q;
   logic [7:0]          addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [REG_AW-1:0]   rd_idx_q;

   logic                reg_we;
   logic [REG_AW-1:0]   reg_waddr;
   logic [DATA_W-1:0]   reg_wdata;

   assign opcode      = INSTRUCTION[31:24];
   assign off         = INSTRUCTION[23:16];
   assign imm         = INSTRUCTION[7:0];
   assign shamt       = imm[4:0];
   assign rd_idx      = INSTRUCTION[16 +: REG_AW];
   assign rs1_idx     = INSTRUCTION[8 +: REG_AW];
   assign rs2_idx     = INSTRUCTION[0 +: REG_AW];
   assign unused_bits = ^INSTRUCTION[15:8+REG_AW];

   assign rs1_val   = regs[rs1_idx];
   assign rs2_val   = regs[rs2_idx];
   assign pc_plus4  = PC + 32'd4;
   assign br_target = pc_plus4 + {{22{off[7]}}, off, 2'b00};
   assign shift_big = ({27'd0, shamt} >= 32'(DATA_W));
   assign is_mem    = is_load | is_store;

   always_comb begin
      imm_ext      = {DATA_W{imm[7]}};
      imm_ext[7:0] = imm;
   end

   always_comb begin
      alu_res     = '0;
      wr_en       = 1'b0;
      is_load     = 1'b0;
      is_store    = 1'b0;
      take_branch = 1'b0;
      illegal_op  = 1'b0;
      mem_addr_c  = imm;
      case (opcode)
         OP_LOADI: begin alu_res = imm_ext;           wr_en = 1'b1; end
         OP_MOV:   begin alu_res = rs2_val;           wr_en = 1'b1; end
         OP_ADD:   begin alu_res = rs1_val + rs2_val; wr_en = 1'b1; end
         OP_SUB:   begin alu_res = rs1_val - rs2_val; wr_en = 1'b1; end
         OP_AND:   begin alu_res = rs1_val & rs2_val; wr_en = 1'b1; end
         OP_OR:    begin alu_res = rs1_val | rs2_val; wr_en = 1'b1; end
         OP_J:     take_branch = 1'b1;
         OP_BEQ:   take_branch = (rs1_val == rs2_val);
         OP_BNE:   take_branch = (rs1_val != rs2_val);
         OP_LWD:   begin is_load = 1'b1;  mem_addr_c = rs2_val[7:0]; end
         OP_LWI:   is_load = 1'b1;
         OP_SWD:   begin is_store = 1'b1; mem_addr_c = rs2_val[7:0]; end
         OP_SWI:   is_store = 1'b1;
         OP_SLL:   begin alu_res = shift_big ? '0 : (rs1_val << shamt); wr_en = 1'b1; end
         OP_SRL:   begin alu_res = shift_big ? '0 : (rs1_val >> shamt); wr_en = 1'b1; end
         default:  illegal_op = 1'b1;
      endcase
   end

   // Memory handshake: a strobe stays high until the first edge with
   // BUSYWAIT=0, which completes the access; the following cycle is forced
   // idle so back-to-back accesses are separated by a strobe-low gap.
   always_comb begin
      state_nx  = state;
      pc_nx     = PC;
      gap_nx    = gap_q;
      reg_we    = 1'b0;
      reg_waddr = rd_idx;
      reg_wdata = alu_res;
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      MEM_ADDR  = mem_addr_c;
      MEM_WDATA = rs1_val;
      ILLEGAL   = 1'b0;
      if (!RESET) begin
         case (state)
            EXEC: begin
               if (is_mem) begin
                  if (gap_q) begin
                     gap_nx = 1'b0;
                  end else begin
                     MEM_READ  = is_load;
                     MEM_WRITE = is_store;
                     if (BUSYWAIT) begin
                        state_nx = MEM_WAIT;
                     end else begin
                        pc_nx     = pc_plus4;
                        reg_we    = is_load;
                        reg_wdata = MEM_RDATA;
                        gap_nx    = 1'b1;
                     end
                  end
               end else begin
                  gap_nx  = 1'b0;
                  ILLEGAL = illegal_op;
                  reg_we  = wr_en;
                  pc_nx   = take_branch ? br_target : pc_plus4;
               end
            end
            MEM_WAIT: begin
               MEM_READ  = rd_q;
               MEM_WRITE = wr_q;
               MEM_ADDR  = addr_q;
               MEM_WDATA = wdata_q;
               reg_waddr = rd_idx_q;
               reg_wdata = MEM_RDATA;
               if (!BUSYWAIT) begin
                  state_nx = EXEC;
                  pc_nx    = pc_plus4;
                  reg_we   = rd_q;
                  gap_nx   = 1'b1;
               end
            end
            default: state_nx = EXEC;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= EXEC;
         PC       <= 32'd0;
         gap_q    <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= 8'd0;
         wdata_q  <= '0;
         rd_idx_q <= '0;
      end else begin
         state <= state_nx;
         PC    <= pc_nx;
         gap_q <= gap_nx;
         // Freeze the access so strobe/address/data stay stable while waiting.
         if (state == EXEC && state_nx == MEM_WAIT) begin
            rd_q     <= is_load;
            wr_q     <= is_store;
            addr_q   <= mem_addr_c;
            wdata_q  <= rs1_val;
            rd_idx_q <= rd_idx;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (reg_we) begin
         regs[reg_waddr] <= reg_wdata;
      end
   end

endmodule

// File: doc/cpu_param.md
CPU_PARAM -- requirements
Module: cpu_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register, ALU and memory data width (legal 8..32).
REQ-002 The block SHALL have parameter REG_AW, default 3, meaning register-file address width (2**REG_AW registers).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, on ports named CLK and RESET.
REQ-004 The block SHALL have port CLK, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit, meaning synchronous active-high reset.
REQ-006 The block SHALL have port PC, output, 32 bits, meaning the registered instruction address.
REQ-007 The block SHALL have port INSTRUCTION, input, 32 bits, meaning the instruction at PC, valid in the same cycle.
REQ-008 The block SHALL have port MEM_READ, output, 1 bit, meaning data-memory read strobe.
REQ-009 The block SHALL have port MEM_WRITE, output, 1 bit, meaning data-memory write strobe.
REQ-010 The block SHALL have port MEM_ADDR, output, 8 bits, meaning data-memory address.
REQ-011 The block SHALL have port MEM_WDATA, output, DATA_W bits, meaning store data.
REQ-012 The block SHALL have port MEM_RDATA, input, DATA_W bits, meaning load data, valid in the cycle BUSYWAIT is low.
REQ-013 The block SHALL have port BUSYWAIT, input, 1 bit, meaning the memory is not done; a high value stalls the core.
REQ-014 The block SHALL have port ILLEGAL, output, 1 bit, meaning a one-cycle pulse for an undefined opcode.

Function
REQ-015 Instruction fields SHALL be: opcode [31:24]; dest/offset [23:16]; src1 [15:8]; src2/imm [7:0]. Register indices use the low REG_AW bits of each field.
REQ-016 Immediates SHALL be sign-extended from 8 bits to DATA_W, and all ALU results SHALL be truncated to DATA_W with no overflow flag.
REQ-017 The opcodes SHALL be:
- 0x00 loadi: rd=imm
- 0x01 mov: rd=rs2
- 0x02 add: rd=rs1+rs2
- 0x03 sub: rd=rs1-rs2
- 0x04 and
- 0x05 or
- 0x06 j
- 0x07 beq
- 0x08 bne
- 0x09 lwd: rd=mem[rs2]
- 0x0A lwi: rd=mem[imm]
- 0x0B swd: mem[rs2]=rs1
- 0x0C swi: mem[imm]=rs1
- 0x0D sll: rd=rs1<<imm[4:0]
- 0x0E srl: rd=rs1>>imm[4:0], logical
REQ-018 Shift amounts >= DATA_W SHALL yield 0.
REQ-019 Branch/jump target SHALL be PC+4 + (sign-extended offset[23:16] << 2), computed in 32-bit wrap-around arithmetic.
REQ-020 j SHALL always take the target; beq SHALL take it when rs1==rs2 over the full DATA_W; bne SHALL take it when they differ; otherwise PC SHALL advance by 4.
REQ-021 Non-memory instructions SHALL complete in one cycle: register write and PC update on the same rising edge.
REQ-022 Register reads SHALL be combinational; register 0 SHALL be general purpose, not hardwired.
REQ-023 The controller SHALL be a two-state FSM, EXEC and MEM_WAIT, with reset state EXEC.
REQ-024 In EXEC with a memory opcode, the block SHALL assert MEM_READ or MEM_WRITE combinationally and drive MEM_ADDR and MEM_WDATA; if BUSYWAIT=1 it SHALL move to MEM_WAIT.
REQ-025 In MEM_WAIT the strobe, MEM_ADDR and MEM_WDATA SHALL hold stable, and the PC and register file SHALL be frozen.
REQ-026 On the first rising edge with BUSYWAIT=0, a load SHALL write MEM_RDATA[DATA_W-1:0] into rd, the PC SHALL advance by 4, and the FSM SHALL return to EXEC.
REQ-027 After memory completion the strobes SHALL be low for at least one cycle before the next memory access, which gives back-to-back accesses a 1-cycle gap.
REQ-028 A memory access with BUSYWAIT=0 in the first cycle SHALL complete in 1 cycle.
REQ-029 MEM_READ and MEM_WRITE SHALL never be high simultaneously; with no memory opcode both SHALL be 0 and MEM_ADDR/MEM_WDATA SHALL be don't-care.
REQ-030 An undefined opcode SHALL execute as a NOP (no write, PC+4) and SHALL pulse ILLEGAL for that cycle only.
REQ-031 A PC increment from 0xFFFFFFFC SHALL wrap to 0x00000000.

Reset
REQ-032 RESET=1 at a rising edge SHALL set PC=0, all registers=0, FSM=EXEC and ILLEGAL=0.
REQ-033 While RESET=1, MEM_READ and MEM_WRITE SHALL be 0.
REQ-034 RESET SHALL take priority over BUSYWAIT and over all instruction effects.
REQ-035 A reset during MEM_WAIT SHALL abort the access: no register write, strobes low from the reset cycle, and execution SHALL restart at PC=0 on the first edge after RESET falls.

Verification
REQ-036 The bench SHALL cover: DATA_W=8; loadi r1,5; loadi r2,3; sub r3,r1,r2 -> r3=2 and PC=12 after 3 edges.
REQ-037 The bench SHALL cover: DATA_W=16; loadi r1,0x80 -> r1=0xFF80; add r2,r1,r1 -> r2=0xFF00.
REQ-038 The bench SHALL cover: at PC=8, beq offset=-3 with equal regs -> PC=0; bne with the same regs -> PC=12.
REQ-039 The bench SHALL cover: swi r1 (value 0x2A) to 0x10 with BUSYWAIT high for 3 cycles -> MEM_WRITE high 4 cycles, MEM_ADDR=0x10, PC frozen, then PC+4 and MEM_WRITE low next cycle.
REQ-040 The bench SHALL cover: lwd with BUSYWAIT high and RESET asserted in the 2nd wait cycle -> MEM_READ low, rd unchanged (0), PC=0.
REQ-041 The bench SHALL cover: opcode 0xFF -> ILLEGAL high exactly 1 cycle, registers unchanged, PC+4.
